// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU execute/memory stage, port 1 is a loader/DMA that may burst.
// Optional build macro ARB_CONTADORES_EN adds saturating statistics counters.
`timescale 1ns/1ps
module arbitro_memoria_dados #(
  parameter int unsigned LARGURA     = 16,
  parameter int unsigned LAT_LEITURA = 1,
  parameter int unsigned MAX_RAJADA  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               we0,
  input  logic [LARGURA-1:0] end0,
  input  logic [LARGURA-1:0] dado0,
  output logic               gnt0,
  output logic               espera0,
  output logic               rvalid0,
  input  logic               req1,
  input  logic               we1,
  input  logic [LARGURA-1:0] end1,
  input  logic [LARGURA-1:0] dado1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [LARGURA-1:0] rdata,
  output logic               mem_we,
  output logic [LARGURA-1:0] mem_end,
  output logic [LARGURA-1:0] mem_dado,
  input  logic [LARGURA-1:0] mem_rdata
`ifdef ARB_CONTADORES_EN
  ,
  output logic [15:0]        cont_conflito,
  output logic [15:0]        cont_espera0,
  output logic [7:0]         cont_rajada_max
`endif
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_SAT  = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_RAJADA);

  typedef enum logic {
    LIVRE   = 1'b0,
    RAJADA1 = 1'b1
  } estado_t;

  estado_t          estado_q, estado_d;
  logic             ultimo_q, ultimo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_c, gnt1_c;
  logic             leitura_c;

  // Read-return pipeline: valid bit and issuing port per stage.
  logic [LAT_LEITURA-1:0] rv_q;
  logic [LAT_LEITURA-1:0] porta_q;

  // State register for the arbitration FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= LIVRE;
      ultimo_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      ultimo_q <= ultimo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and grant decision: round-robin when idle, bounded port-1 bursts.
  always_comb begin
    estado_d = estado_q;
    ultimo_d = ultimo_q;
    cnt_d    = cnt_q;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    case (estado_q)
      LIVRE: begin
        if (req0 && (!req1 || ultimo_q)) begin
          gnt0_c   = 1'b1;
          ultimo_d = 1'b0;
        end else if (req1) begin
          gnt1_c   = 1'b1;
          ultimo_d = 1'b1;
          cnt_d    = CNT_W'(1);
          estado_d = RAJADA1;
        end
      end
      RAJADA1: begin
        if (req1 && ((cnt_q < CNT_LIM) || !req0)) begin
          gnt1_c = 1'b1;
          cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (req0) begin
          gnt0_c   = 1'b1;
          ultimo_d = 1'b0;
          estado_d = LIVRE;
        end else begin
          estado_d = LIVRE;
        end
      end
      default: estado_d = LIVRE;
    endcase
  end

  // Memory command mux; everything forced low while reset is asserted.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    espera0  = 1'b0;
    mem_we   = 1'b0;
    mem_end  = '0;
    mem_dado = '0;
    rdata    = '0;
    if (reset) begin
      gnt0    = gnt0_c;
      gnt1    = gnt1_c;
      espera0 = req0 & ~gnt0_c;
      rdata   = mem_rdata;
      if (gnt0_c) begin
        mem_we   = we0;
        mem_end  = end0;
        mem_dado = dado0;
      end else if (gnt1_c) begin
        mem_we   = we1;
        mem_end  = end1;
        mem_dado = dado1;
      end
    end
  end

  assign leitura_c = (gnt0_c & ~we0) | (gnt1_c & ~we1);

  // Shift each granted read toward its return slot LAT_LEITURA cycles later.
  if (LAT_LEITURA > 1) begin : g_ret_multi
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rv_q    <= '0;
        porta_q <= '0;
      end else begin
        rv_q    <= {rv_q[LAT_LEITURA-2:0], leitura_c};
        porta_q <= {porta_q[LAT_LEITURA-2:0], gnt1_c};
      end
    end
  end else begin : g_ret_single
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rv_q    <= '0;
        porta_q <= '0;
      end else begin
        rv_q    <= leitura_c;
        porta_q <= gnt1_c;
      end
    end
  end

  assign rvalid0 = rv_q[LAT_LEITURA-1] & ~porta_q[LAT_LEITURA-1];
  assign rvalid1 = rv_q[LAT_LEITURA-1] &  porta_q[LAT_LEITURA-1];

`ifdef ARB_CONTADORES_EN
  logic [15:0]      conflito_q;
  logic [15:0]      espera0_q;
  logic [CNT_W-1:0] rajada_max_q;

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflito_q   <= '0;
      espera0_q    <= '0;
      rajada_max_q <= '0;
    end else begin
      if (req0 && req1 && (conflito_q != 16'hFFFF)) begin
        conflito_q <= conflito_q + 16'd1;
      end
      if (espera0 && (espera0_q != 16'hFFFF)) begin
        espera0_q <= espera0_q + 16'd1;
      end
      if (cnt_d > rajada_max_q) begin
        rajada_max_q <= cnt_d;
      end
    end
  end

  assign cont_conflito   = conflito_q;
  assign cont_espera0    = espera0_q;
  assign cont_rajada_max = rajada_max_q;
`endif

endmodule
